// File: rtl/param_arith_pkg.sv
// Shared types and constants for the parameterised arithmetic blocks:
// the IDLE/RUN/DONE state encoding and the default operand width.
package param_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/param_mul_step.sv
// One shift-and-add multiplication step: conditionally adds the shifted
// multiplicand into the accumulator, then advances both operand shifters.
module param_mul_step
  import param_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [2*WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0]   i_mplier,
  output logic [2*WIDTH-1:0] o_acc,
  output logic [2*WIDTH-1:0] o_mcand,
  output logic [WIDTH-1:0]   o_mplier
);

  // The accumulator is 2*WIDTH wide, so the running sum cannot carry out.
  assign o_acc    = i_mplier[0] ? (i_acc + i_mcand) : i_acc;
  assign o_mcand  = i_mcand << 1;
  assign o_mplier = i_mplier >> 1;

endmodule

// File: rtl/param_seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier (WIDTH >= 2) with valid/ready
// operand and result ports. Define PARAM_SEQ_MUL_EARLY_TERM_EN to finish as
// soon as the remaining multiplier bits are all zero.
module param_seq_multiplier
  import param_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output state_e             dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high; in_ready is high only in IDLE, out_valid only in DONE,
  // and product is meaningful only while out_valid is high.

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_e r_state, w_state_next;

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_product;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;

  logic [2*WIDTH-1:0] w_acc_step;
  logic [2*WIDTH-1:0] w_mcand_step;
  logic [WIDTH-1:0]   w_mplier_step;
  logic               w_accept;
  logic               w_release;
  logic               w_last;

  param_mul_step #(.WIDTH(WIDTH)) u_step (
    .i_acc    (r_acc),
    .i_mcand  (r_mcand),
    .i_mplier (r_mplier),
    .o_acc    (w_acc_step),
    .o_mcand  (w_mcand_step),
    .o_mplier (w_mplier_step)
  );

  assign w_accept  = in_valid && in_ready;
  assign w_release = out_valid && out_ready;

`ifdef PARAM_SEQ_MUL_EARLY_TERM_EN
  assign w_last = (w_mplier_step == '0) || (r_cnt == LAST_STEP);
`else
  assign w_last = (r_cnt == LAST_STEP);
`endif

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (w_accept) w_state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (w_release) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // r_product is loaded only when the final step completes, so it holds the
  // previous result through IDLE and RUN and partial sums are never shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, multiplicand};
      r_mplier <= multiplier;
      r_cnt    <= '0;
    end else if (r_state == RUN) begin
      r_acc    <= w_acc_step;
      r_mcand  <= w_mcand_step;
      r_mplier <= w_mplier_step;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) r_product <= w_acc_step;
    end
  end

  assign product   = r_product;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_param_seq_multiplier.sv
// Bench for param_seq_multiplier: directed and random operations on a
// WIDTH=8 instance, plus random back-to-back streams at WIDTH=4 and 16.
module tb_param_seq_multiplier;
  import param_arith_pkg::*;

  localparam int MW     = 8;
  localparam int RAND_N = 40;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference latency: full WIDTH steps, or with early termination the
  // position of the highest set multiplier bit plus one (at least 1).
  function automatic int exp_lat(input int w, input logic [63:0] b);
    int l;
`ifdef PARAM_SEQ_MUL_EARLY_TERM_EN
    l = 1;
    for (int i = 0; i < w; i++) if (b[i]) l = i + 1;
`else
    l = w;
`endif
    return l;
  endfunction

  // ---------------- WIDTH=8 instance ----------------
  logic            m_iv, m_ir, m_ov, m_ordy, m_bz;
  logic [MW-1:0]   m_a, m_b;
  logic [2*MW-1:0] m_p;
  state_e          m_dbg;
  logic [2*MW-1:0] last_p;

  param_seq_multiplier #(.WIDTH(MW)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (m_iv),
    .in_ready     (m_ir),
    .multiplicand (m_a),
    .multiplier   (m_b),
    .out_valid    (m_ov),
    .out_ready    (m_ordy),
    .product      (m_p),
    .busy         (m_bz),
    .dbg_state    (m_dbg)
  );

  // Driver: called at a negedge with the block idle; returns at a negedge
  // after the result handshake, block idle again.
  task automatic do_op(input logic [MW-1:0] a, input logic [MW-1:0] b, input int hold);
    int n;
    logic [2*MW-1:0] e;
    e = a * b;
    check("ready_idle", m_ir, 1);
    m_a = a; m_b = b; m_iv = 1'b1;
    @(negedge clk);
    m_iv = 1'b0;
    check("busy_run", m_bz, 1);
    check("prod_hold_run", m_p, last_p);
    n = 0;
    while (!m_ov && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, exp_lat(MW, b));
    check("product", m_p, e);
    for (int i = 0; i < hold; i++) begin
      m_ordy = 1'b0;
      m_iv = 1'b1; m_a = ~a; m_b = ~b;
      @(negedge clk);
      check("hold_valid", m_ov, 1);
      check("hold_prod", m_p, e);
      check("ready_done", m_ir, 0);
    end
    m_iv = 1'b0;
    m_ordy = 1'b1;
    @(negedge clk);
    m_ordy = 1'b0;
    check("valid_drop", m_ov, 0);
    check("ready_back", m_ir, 1);
    check("busy_idle", m_bz, 0);
    check("prod_keep", m_p, e);
    last_p = e;
  endtask

  // ---------------- random streams at WIDTH=4 and WIDTH=16 ----------------
  logic       rand_go;
  logic [1:0] rand_done;

  for (genvar g = 0; g < 2; g++) begin : g_rand
    localparam int W = (g == 0) ? 4 : 16;
    logic           iv, ir, ov, ordy, bz;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] p;
    state_e         dbg;
    logic [2*W-1:0] exp_q[$];

    param_seq_multiplier #(.WIDTH(W)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (iv),
      .in_ready     (ir),
      .multiplicand (a),
      .multiplier   (b),
      .out_valid    (ov),
      .out_ready    (ordy),
      .product      (p),
      .busy         (bz),
      .dbg_state    (dbg)
    );

    initial begin : driver
      logic [2*W-1:0] e;
      int t;
      iv = 1'b0; a = '0; b = '0;
      wait (rand_go);
      @(negedge clk);
      for (int n = 0; n < RAND_N; n++) begin
        a = W'($urandom);
        b = W'($urandom);
        if ($urandom_range(0, 7) == 0) b = '1;
        if ($urandom_range(0, 7) == 0) a = '0;
        iv = 1'b1;
        t = 0;
        while (!ir && t < 200) begin
          @(negedge clk);
          a = ~a;
          a = ~a;
          t++;
        end
        check($sformatf("w%0d_accept", W), ir, 1);
        e = a * b;
        exp_q.push_back(e);
        @(negedge clk);
        iv = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    initial begin : monitor
      int got;
      got = 0;
      ordy = 1'b0;
      wait (rand_go);
      for (int c = 0; c < RAND_N * (W + 20) && got < RAND_N; c++) begin
        @(negedge clk);
        ordy = ($urandom_range(0, 3) != 0);
        if (ov && ordy) begin
          check($sformatf("w%0d_q_nonempty", W), 64'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check($sformatf("w%0d_prod", W), p, exp_q.pop_front());
          got++;
        end
      end
      @(negedge clk);
      ordy = 1'b0;
      check($sformatf("w%0d_count", W), got, RAND_N);
      check($sformatf("w%0d_q_empty", W), exp_q.size(), 0);
      rand_done[g] = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int t;
    rst_n = 1'b0;
    m_iv = 1'b0; m_ordy = 1'b0; m_a = '0; m_b = '0;
    rand_go = 1'b0; rand_done = 2'b00; last_p = '0;

    repeat (2) @(negedge clk);
    check("rst_ready", m_ir, 1);
    check("rst_valid", m_ov, 0);
    check("rst_busy", m_bz, 0);
    check("rst_prod", m_p, 0);
    check("rst_state", m_dbg, IDLE);

    // Accept on the very first edge after release.
    rst_n = 1'b1;
    do_op(8'd13, 8'd11, 0);
    do_op(8'd255, 8'd255, 0);
    do_op(8'd13, 8'd11, 5);

    // Abort mid-RUN with an asynchronous reset.
    m_a = 8'd200; m_b = 8'd7; m_iv = 1'b1;
    @(negedge clk);
    m_iv = 1'b0;
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_valid", m_ov, 0);
    check("abort_busy", m_bz, 0);
    check("abort_ready", m_ir, 1);
    check("abort_prod", m_p, 0);
    check("abort_state", m_dbg, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    last_p = '0;
    do_op(8'd3, 8'd5, 0);

    // Multiplier patterns that exercise early termination.
    do_op(8'd77, 8'd0, 0);
    do_op(8'd9, 8'd1, 0);
    do_op(8'd3, 8'h80, 0);
    do_op(8'd6, 8'd5, 1);

    for (int i = 0; i < 20; i++)
      do_op(MW'($urandom), MW'($urandom), $urandom_range(0, 2));

    rand_go = 1'b1;
    t = 0;
    while (rand_done != 2'b11 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("rand_done", rand_done, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_seq_multiplier.md
PARAM_SEQ_MULTIPLIER -- requirements
Module: param_seq_multiplier

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; WIDTH SHALL be at least 2.
REQ-002 Port: clk, input, 1, the single clock; all state SHALL update on the rising edge.
REQ-003 Port: rst_n, input, 1, reset; reset SHALL be asynchronous and active-low.
REQ-004 Port: in_valid, input, 1, operand pair is presented.
REQ-005 Port: in_ready, output, 1, block accepts operands.
REQ-006 Port: multiplicand, input, WIDTH, unsigned operand A.
REQ-007 Port: multiplier, input, WIDTH, unsigned operand B.
REQ-008 Port: out_valid, output, 1, product is available.
REQ-009 Port: out_ready, input, 1, consumer takes the product.
REQ-010 Port: product, output, 2*WIDTH, unsigned A*B.
REQ-011 Port: busy, output, 1, high in RUN or DONE.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; in_valid in RUN or DONE SHALL be ignored.
REQ-014 Acceptance SHALL occur on the edge where in_valid and in_ready are both 1.
REQ-015 At acceptance, the block SHALL latch the operands, clear the accumulator and step counter, and enter RUN.
REQ-016 Each RUN edge SHALL add the shifted multiplicand to the 2*WIDTH-bit accumulator when the current multiplier LSB is 1, then shift the multiplier right by 1, shift the multiplicand left by 1, and increment the counter.
REQ-017 RUN SHALL go to DONE on the edge that processes step WIDTH-1, so out_valid rises exactly WIDTH edges after acceptance.
REQ-018 The accumulator is 2*WIDTH bits and SHALL never overflow; no carry is lost.
REQ-019 In DONE, out_valid SHALL be 1 and product SHALL equal A*B; product SHALL be held stable while out_ready is 0.
REQ-020 DONE SHALL return to IDLE on the edge where out_valid and out_ready are both 1; in_ready SHALL be 1 on the next cycle.
REQ-021 No new operands are accepted in the handshake cycle, so the minimum throughput is one result per WIDTH+2 cycles.
REQ-022 product SHALL keep its last value in IDLE and RUN, and SHALL be qualified only by out_valid.

Reset
REQ-023 While rst_n is 0: state SHALL be IDLE, in_ready 1, out_valid 0, busy 0, product 0, and all internal registers 0.
REQ-024 Reset asserted during RUN or DONE SHALL abort the operation immediately; the partial result SHALL be discarded and never presented.
REQ-025 After reset release, the first acceptance SHALL be possible on the first rising edge.

Configuration
REQ-026 Macro: PARAM_SEQ_MUL_EARLY_TERM_EN.
REQ-027 With PARAM_SEQ_MUL_EARLY_TERM_EN defined, RUN SHALL go to DONE on the first edge after which the shifted multiplier is 0.
REQ-028 With the macro defined, latency SHALL be max(1, index of the highest set bit of B + 1) edges; B=0 SHALL give latency 1 and product 0.
REQ-029 Without PARAM_SEQ_MUL_EARLY_TERM_EN, latency SHALL always be WIDTH edges.
REQ-030 The product value SHALL be identical with and without the macro.

Structure
REQ-031 Shared package param_arith_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default WIDTH constant, reused by the arithmetic blocks.
REQ-032 The step counter width SHALL be $clog2(WIDTH).
REQ-033 One sub-module is natural: param_mul_step, a combinational conditional-add and shift stage; instantiating it is optional.

Verification
REQ-034 WIDTH=8, A=13, B=11, out_ready=1 -> out_valid 8 edges after acceptance, product=143, in_ready high 2 cycles later.
REQ-035 WIDTH=8, A=255, B=255 -> product=65025 (0xFE01) with no truncation.
REQ-036 out_ready held 0 for 5 cycles in DONE -> out_valid and product=143 remain stable; a new in_valid is ignored until IDLE.
REQ-037 rst_n pulled low on RUN step 4 -> outputs read zero immediately; after release, A=3, B=5 gives product 15 with normal latency.
REQ-038 PARAM_SEQ_MUL_EARLY_TERM_EN defined: B=0 -> latency 1, product 0; B=1 -> latency 1; B=0x80 -> latency 8; A=6, B=5 -> latency 3, product 30.
REQ-039 Random back-to-back operands at WIDTH=4 and WIDTH=16 -> every product equals the reference A*B and no transaction is lost or duplicated.
